// File: rtl/vita_tx_csma_gate.sv
// Listen-before-talk gate between the VITA TX deframer and TX controller.
// Holds bursts at SOB until the medium is clear, with exponential backoff.
module vita_tx_csma_gate #(
    parameter int MAXCHAN     = 1,
    parameter int FIFOWIDTH   = 5 + 64 + 16 + 32 * MAXCHAN,
    parameter int BASE        = 0,
    parameter int CW_MIN      = 3,
    parameter int CW_MAX      = 10,
    parameter int MAX_RETRIES = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic [MAXCHAN-1:0]   carrier_present,
    input  logic [FIFOWIDTH-1:0] sample_fifo_i,
    input  logic                 sample_fifo_src_rdy_i,
    output logic                 sample_fifo_dst_rdy_o,
    output logic [FIFOWIDTH-1:0] sample_fifo_o,
    output logic                 sample_fifo_src_rdy_o,
    input  logic                 sample_fifo_dst_rdy_i,
    output logic                 error,
    output logic [31:0]          error_code,
    output logic [2:0]           state_o,
    output logic [15:0]          backoff_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SENSE   = 3'd1,
        S_BACKOFF = 3'd2,
        S_PASS    = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    localparam logic [7:0]  A_CTRL   = 8'(BASE);
    localparam logic [7:0]  A_SLOT   = 8'(BASE + 1);
    localparam logic [7:0]  A_TIME   = 8'(BASE + 2);
    localparam logic [31:0] CODE_BSY = 32'h0000_0020;
    localparam logic [31:0] CODE_TMO = 32'h0000_0040;

    state_t             r_state;
    logic               r_enable;
    logic [MAXCHAN-1:0] r_mask;
    logic [15:0]        r_slot_len;
    logic [15:0]        r_difs;
    logic [15:0]        r_timeout;
    logic               r_busy;
    logic [15:0]        r_slot_cnt;
    logic [15:0]        r_lfsr;
    logic [7:0]         r_retry;
    logic [15:0]        r_wait;
    logic [15:0]        r_clear;
    logic [15:0]        r_backoff;
    logic               r_error;
    logic [31:0]        r_error_code;

    logic        w_sob;
    logic        w_eob;
    logic        w_start;
    logic [15:0] w_slot_len;
    logic        w_tick;
    logic        w_tmo;
    logic [15:0] w_lfsr_nxt;
    logic [7:0]  w_retry_nxt;
    logic [4:0]  w_cw;
    logic [15:0] w_draw;
    logic        w_src_rdy;
    logic        w_dst_rdy;

    assign w_sob      = sample_fifo_i[FIFOWIDTH-4];
    assign w_eob      = sample_fifo_i[FIFOWIDTH-3];
    assign w_start    = r_enable && sample_fifo_src_rdy_i && w_sob;
    assign w_slot_len = (r_slot_len == 16'd0) ? 16'd1 : r_slot_len;
    assign w_tick     = (r_slot_cnt >= w_slot_len - 16'd1);
    assign w_tmo      = w_tick && (r_timeout != 16'd0)
                        && (r_wait + 16'd1 >= r_timeout);
    // Galois form of x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_retry_nxt = r_retry + 8'd1;

    always_comb begin
        w_cw = 5'(CW_MAX);
        if (CW_MIN + 32'(w_retry_nxt) < CW_MAX)
            w_cw = 5'(CW_MIN + 32'(w_retry_nxt));
        w_draw = r_lfsr & ((16'd1 << w_cw) - 16'd1);
    end

    always_comb begin
        w_src_rdy = 1'b0;
        w_dst_rdy = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_start) begin
                    w_src_rdy = sample_fifo_src_rdy_i;
                    w_dst_rdy = sample_fifo_dst_rdy_i;
                end
            end
            S_PASS: begin
                w_src_rdy = sample_fifo_src_rdy_i;
                w_dst_rdy = sample_fifo_dst_rdy_i;
            end
            S_DROP:  w_dst_rdy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_enable     <= 1'b0;
            r_mask       <= '0;
            r_slot_len   <= '0;
            r_difs       <= '0;
            r_timeout    <= '0;
            r_busy       <= 1'b0;
            r_slot_cnt   <= '0;
            r_lfsr       <= 16'hACE1;
            r_retry      <= '0;
            r_wait       <= '0;
            r_clear      <= '0;
            r_backoff    <= '0;
            r_error      <= 1'b0;
            r_error_code <= '0;
        end else begin
            r_error    <= 1'b0;
            r_lfsr     <= w_lfsr_nxt;
            r_busy     <= |(carrier_present & r_mask);
            r_slot_cnt <= w_tick ? 16'd0 : r_slot_cnt + 16'd1;
            if (set_stb) begin
                if (set_addr == A_CTRL) begin
                    r_enable <= set_data[0];
                    r_mask   <= set_data[MAXCHAN:1];
                end
                if (set_addr == A_SLOT)
                    r_slot_len <= set_data[15:0];
                if (set_addr == A_TIME) begin
                    r_difs    <= set_data[15:0];
                    r_timeout <= set_data[31:16];
                end
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_SENSE;
                        r_retry    <= '0;
                        r_wait     <= '0;
                        r_clear    <= '0;
                        r_slot_cnt <= '0;
                    end
                end
                S_SENSE: begin
                    if (w_tick)
                        r_wait <= r_wait + 16'd1;
                    if (w_tmo) begin
                        r_state      <= S_DROP;
                        r_error      <= 1'b1;
                        r_error_code <= CODE_TMO;
                    end else if (r_busy) begin
                        if (r_retry >= 8'(MAX_RETRIES)) begin
                            r_state      <= S_DROP;
                            r_error      <= 1'b1;
                            r_error_code <= CODE_BSY;
                        end else begin
                            r_state    <= S_BACKOFF;
                            r_retry    <= w_retry_nxt;
                            r_backoff  <= w_draw;
                            r_slot_cnt <= '0;
                        end
                    end else if (w_tick) begin
                        if (r_clear + 16'd1 >= r_difs)
                            r_state <= S_PASS;
                        else
                            r_clear <= r_clear + 16'd1;
                    end
                end
                S_BACKOFF: begin
                    if (w_tick)
                        r_wait <= r_wait + 16'd1;
                    if (r_backoff == 16'd0) begin
                        r_state    <= S_SENSE;
                        r_clear    <= '0;
                        r_slot_cnt <= '0;
                    end else if (w_tmo) begin
                        r_state      <= S_DROP;
                        r_error      <= 1'b1;
                        r_error_code <= CODE_TMO;
                        r_backoff    <= '0;
                    end else if (w_tick && !r_busy) begin
                        r_backoff <= r_backoff - 16'd1;
                    end
                end
                S_PASS: begin
                    if (sample_fifo_src_rdy_i && sample_fifo_dst_rdy_i && w_eob)
                        r_state <= S_IDLE;
                end
                S_DROP: begin
                    if (sample_fifo_src_rdy_i && w_eob)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sample_fifo_o         = sample_fifo_i;
    assign sample_fifo_src_rdy_o = w_src_rdy;
    assign sample_fifo_dst_rdy_o = w_dst_rdy;
    assign error                 = r_error;
    assign error_code            = r_error_code;
    assign state_o               = r_state;
    assign backoff_o             = r_backoff;

endmodule

// File: tb/tb_vita_tx_csma_gate.sv
// Bench for vita_tx_csma_gate: queued expected words, negedge output monitor.
module tb_vita_tx_csma_gate;

    localparam int MAXCHAN = 1;
    localparam int FW      = 5 + 64 + 16 + 32 * MAXCHAN;
    localparam int BUDGET  = 6000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               set_stb = 1'b0;
    logic [7:0]         set_addr = '0;
    logic [31:0]        set_data = '0;
    logic [MAXCHAN-1:0] carrier_present;
    logic [FW-1:0]      sample_fifo_i = '0;
    logic               sample_fifo_src_rdy_i = 1'b0;
    logic               sample_fifo_dst_rdy_o;
    logic [FW-1:0]      sample_fifo_o;
    logic               sample_fifo_src_rdy_o;
    logic               sample_fifo_dst_rdy_i = 1'b1;
    logic               error;
    logic [31:0]        error_code;
    logic [2:0]         state_o;
    logic [15:0]        backoff_o;

    logic r_car = 1'b0;
    logic car_auto = 1'b0;
    logic car_tog = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    logic [FW-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign carrier_present = car_auto ? {MAXCHAN{state_o == 3'd1}}
                                      : {MAXCHAN{r_car}};

    vita_tx_csma_gate #(.MAXCHAN(MAXCHAN)) dut (
        .clk                   (clk),
        .reset                 (rst_n),
        .set_stb               (set_stb),
        .set_addr              (set_addr),
        .set_data              (set_data),
        .carrier_present       (carrier_present),
        .sample_fifo_i         (sample_fifo_i),
        .sample_fifo_src_rdy_i (sample_fifo_src_rdy_i),
        .sample_fifo_dst_rdy_o (sample_fifo_dst_rdy_o),
        .sample_fifo_o         (sample_fifo_o),
        .sample_fifo_src_rdy_o (sample_fifo_src_rdy_o),
        .sample_fifo_dst_rdy_i (sample_fifo_dst_rdy_i),
        .error                 (error),
        .error_code            (error_code),
        .state_o               (state_o),
        .backoff_o             (backoff_o)
    );

    // output monitor: every presented word must be the next expected one
    always @(negedge clk) begin
        if (rst_n && sample_fifo_src_rdy_o && sample_fifo_dst_rdy_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected got=%h", sample_fifo_o);
            end else begin
                logic [FW-1:0] w;
                w = exp_q.pop_front();
                if (sample_fifo_o !== w) begin
                    n_bad++;
                    $display("FAIL out_data got=%h exp=%h", sample_fifo_o, w);
                end
            end
        end
    end

    always @(negedge clk)
        if (error) n_err++;

    always begin
        @(posedge clk);
        #2;
        if (car_tog) r_car = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [4:0] f, input int v);
        logic [FW-1:0] w;
        w = '0;
        w[31:0]  = 32'(v);
        w[63:32] = ~32'(v);
        w[FW-1:FW-5] = f;
        return w;
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic send_burst(input int n, input int tag, input bit pass,
                              output int first_stall);
        int k;
        first_stall = 0;
        for (int i = 0; i < n; i++) begin
            sample_fifo_i = mk({1'b0, i == n - 1, i == n - 1, i == 0, 1'b0},
                               tag * 16 + i);
            sample_fifo_src_rdy_i = 1'b1;
            if (pass) exp_q.push_back(sample_fifo_i);
            k = 0;
            @(negedge clk);
            while (!sample_fifo_dst_rdy_o && k < BUDGET) begin
                k++;
                @(negedge clk);
            end
            if (k >= BUDGET) begin
                n_cmp++;
                n_bad++;
                $display("FAIL xfer_timeout tag=%0d word=%0d", tag, i);
            end
            if (i == 0) first_stall = k;
            @(posedge clk);
            #1;
        end
        sample_fifo_src_rdy_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (state_o != s && k < 500) begin
            k++;
            @(negedge clk);
        end
        if (k >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s state=%0d exp=%0d", nm, state_o, s);
        end
    endtask

    initial begin
        int st;
        int e0;
        int cyc;
        logic [15:0] b;

        #1;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_code", 64'(error_code), 64'd0);
        chk("rst_backoff", 64'(backoff_o), 64'd0);
        chk("rst_src_rdy", 64'(sample_fifo_src_rdy_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // disabled: transparent regardless of carrier
        car_tog = 1'b1;
        send_burst(3, 1, 1'b1, st);
        chk("thru_stall_b1", 64'(st), 64'd0);
        send_burst(4, 2, 1'b1, st);
        chk("thru_stall_b2", 64'(st), 64'd0);
        send_burst(2, 3, 1'b1, st);
        chk("thru_stall_b3", 64'(st), 64'd0);
        car_tog = 1'b0;
        r_car = 1'b0;

        // enabled, quiet medium: slot 4, DIFS 2
        wr(8'd1, 32'd4);
        wr(8'd2, 32'd2);
        wr(8'd0, 32'h3);
        send_burst(4, 4, 1'b1, st);
        n_cmp++;
        if (st + 1 < 8 || st + 1 > 10) begin
            n_bad++;
            $display("FAIL sob_latency got=%0d exp=8..10", st + 1);
        end
        chk("idle_after_eob", 64'(state_o), 64'd0);

        // busy medium: backoff freezes while busy
        r_car = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fork
            send_burst(3, 5, 1'b1, st);
            begin
                wait_state(3'd2, "enter_backoff");
                n_cmp++;
                if (backoff_o > 16'd15) begin
                    n_bad++;
                    $display("FAIL first_draw got=%0d exp=0..15", backoff_o);
                end
                cyc = 0;
                while (!(state_o == 3'd2 && backoff_o != 0) && cyc < 500) begin
                    cyc++;
                    @(negedge clk);
                end
                b = backoff_o;
                repeat (50) @(negedge clk);
                chk("frozen_backoff", 64'(backoff_o), 64'(b));
                chk("frozen_state", 64'(state_o), 64'd2);
                r_car = 1'b0;
                repeat (10) @(negedge clk);
                chk("resume_count",
                    64'(backoff_o < b || state_o != 3'd2), 64'd1);
            end
        join

        // retry exhaustion: busy in every sense window
        wr(8'd1, 32'd1);
        wr(8'd2, 32'd4);
        car_auto = 1'b1;
        e0 = n_err;
        send_burst(3, 6, 1'b0, st);
        chk("busy_err_pulses", 64'(n_err - e0), 64'd1);
        chk("busy_code", 64'(error_code), 64'h20);
        chk("busy_idle", 64'(state_o), 64'd0);
        car_auto = 1'b0;
        send_burst(3, 7, 1'b1, st);

        // timeout: 20 slots of 2 clocks with carrier held busy
        wr(8'd1, 32'd2);
        wr(8'd2, {16'd20, 16'd2});
        r_car = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e0 = n_err;
        fork
            send_burst(2, 8, 1'b0, st);
            begin
                cyc = 0;
                @(negedge clk);
                while (!error && cyc < 500) begin
                    cyc++;
                    @(negedge clk);
                end
                n_cmp++;
                if (cyc < 40 || cyc > 60) begin
                    n_bad++;
                    $display("FAIL tmo_cycles got=%0d exp=40..60", cyc);
                end
            end
        join
        chk("tmo_err_pulses", 64'(n_err - e0), 64'd1);
        chk("tmo_code", 64'(error_code), 64'h40);

        // asynchronous reset in the middle of a backoff
        wr(8'd2, 32'd2);
        sample_fifo_i = mk(5'b00010, 9 * 16);
        sample_fifo_src_rdy_i = 1'b1;
        wait_state(3'd2, "pre_reset_backoff");
        sample_fifo_src_rdy_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(state_o), 64'd0);
        chk("arst_backoff", 64'(backoff_o), 64'd0);
        chk("arst_err", 64'(error), 64'd0);
        chk("arst_code", 64'(error_code), 64'd0);
        chk("arst_src_rdy", 64'(sample_fifo_src_rdy_o), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        r_car = 1'b0;
        wr(8'd1, 32'd4);
        wr(8'd2, 32'd2);
        wr(8'd0, 32'h3);
        sample_fifo_i = mk(5'b00010, 9 * 16);
        sample_fifo_src_rdy_i = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_sense", 64'(state_o), 64'd1);
        send_burst(3, 9, 1'b1, st);

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vita_tx_csma_gate.md
Name: vita_tx_csma_gate

Overview:
- Multi-channel listen-before-talk gate between the VITA TX deframer sample FIFO output and the VITA TX controller input.
- Holds each burst at its SOB word until the selected carrier-sense inputs show the medium clear for a DIFS interval.
- Uses randomized binary-exponential backoff on contention.
- Drops whole bursts and reports an error after too many retries or a wait timeout. Successor to the single-channel carrier hook, generalised in channel count, word width and backoff mode.

Parameters:
MAXCHAN, 1, number of carrier-sense inputs and sample lanes
FIFOWIDTH, 5+64+16+32*MAXCHAN, sample FIFO word width
BASE, 0, settings-bus base address
CW_MIN, 3, log2 of initial contention window
CW_MAX, 10, log2 of maximum contention window
MAX_RETRIES, 7, backoff attempts before burst drop

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
carrier_present  in  MAXCHAN  per-channel carrier detect, level
sample_fifo_i  in  FIFOWIDTH  word from deframer
sample_fifo_src_rdy_i  in  1  input valid
sample_fifo_dst_rdy_o  out  1  input ready
sample_fifo_o  out  FIFOWIDTH  word to controller; equals sample_fifo_i
sample_fifo_src_rdy_o  out  1  output valid
sample_fifo_dst_rdy_i  in  1  output ready
error  out  1  one-cycle drop pulse
error_code  out  32  drop reason, held until next error
state_o  out  3  FSM state, debug
backoff_o  out  16  remaining backoff slots, debug

Behaviour:
- Word flags are the top 5 bits, MSB first: {seqnum_err, eop, eob, sob, send_at}.
- Settings registers, all reset to 0:
  - BASE+0: [0] enable, [MAXCHAN:1] channel mask.
  - BASE+1: [15:0] slot length in clocks; value 0 is treated as 1.
  - BASE+2: [15:0] DIFS slots; [31:16] timeout in slots, 0 = none.
  - Writes take effect the next cycle.
- busy = |(carrier_present & mask), registered one stage. All carrier decisions use the registered value.
- Slot tick: free-running counter that reloads at slot length. The counter resets on entry to SENSE and on entry to BACKOFF.
- Backoff draw: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, steps every clock. Draw = LFSR & ((1<<min(CW_MIN+retry, CW_MAX))-1).
- FSM states, reset to IDLE:
  - IDLE (0): pass-through, src_rdy_o = src_rdy_i and dst_rdy_o = dst_rdy_i. When enable=1 and the head word is valid with sob=1, assert dst_rdy_o=0 and src_rdy_o=0 that cycle and go to SENSE; clear retry and wait counters. When enable=0, IDLE stays pass-through permanently.
  - SENSE (1): stalls both sides. busy at any cycle goes to BACKOFF with a fresh draw and retry+1. DIFS consecutive clear slots go to PASS.
  - BACKOFF (2): stalls. The counter decrements on each slot tick only while busy=0 and freezes while busy. When it reaches 0, go to SENSE.
  - PASS (3): pass-through. A transfer of a word with eob=1 goes to IDLE. A transfer with sob=1 and eob=0 stays in PASS.
  - DROP (4): dst_rdy_o=1, src_rdy_o=0. Consumes words; a consumed eob word goes to IDLE.
- Drop triggers:
  - retry would exceed MAX_RETRIES: error_code=32'h0000_0020 (busy).
  - wait slots counted since SENSE entry reach the timeout: error_code=32'h0000_0040 (timeout).
  - error pulses in the cycle DROP is entered.
  - If the same head word also has eob=1, it is consumed in the first DROP cycle and the FSM returns to IDLE.
- Clearing enable mid-burst: SENSE, BACKOFF and PASS complete normally. DROP completes.
- Reset assertion at any time: state=IDLE, error=0, error_code=0, backoff_o=0, counters=0, registers=0, LFSR=seed. Reset takes effect without a clock.
- No data buffering and no added latency in pass-through; the block is combinational on the data path.
- Ready/valid handshake: a transfer occurs when src_rdy and dst_rdy are both high on a rising edge.

Test Plan:
- Enable=0, stream 3 bursts with the carrier toggling -> bit-exact pass-through with zero-cycle stall.
- Enable=1, mask=1, slot=4, DIFS=2, carrier low, SOB word presented -> first output transfer 8 to 10 clocks after presentation, then the full burst passes.
- Carrier busy during SENSE -> BACKOFF with draw in [0,15] (retry=1). Hold carrier high for 50 clocks -> backoff_o frozen. Release -> countdown resumes and the burst passes.
- Carrier permanently high, MAX_RETRIES=7 -> 8th backoff becomes DROP. error pulses once with code 0x20. All words through EOB are consumed and none reach the output. The next burst is processed normally.
- Timeout=20 slots with carrier always busy -> DROP with code 0x40 after 20 slots.
- Assert reset mid-BACKOFF -> all outputs zero and state 0 immediately (asynchronous). After release, re-presented SOB enters SENSE.
